// File: rtl/rtc_display_if.sv
// Control, time and display signals between the board top level
// and the clock/timer core.
interface rtc_display_if #(
    parameter int DIGITS = 4
);
    logic              run;
    logic              dir;
    logic              h12;
    logic              load;
    logic [4:0]        ld_hour;
    logic [5:0]        ld_min;
    logic [5:0]        ld_sec;
    logic [4:0]        hour;
    logic [5:0]        min;
    logic [5:0]        sec;
    logic              tick;
    logic              done;
    logic              load_err;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;

    modport master (
        output run, dir, h12, load, ld_hour, ld_min, ld_sec,
        input  hour, min, sec, tick, done, load_err, an, seg, dp
    );

    modport slave (
        input  run, dir, h12, load, ld_hour, ld_min, ld_sec,
        output hour, min, sec, tick, done, load_err, an, seg, dp
    );
endinterface

// File: rtl/rtc_display_core.sv
// HH:MM:SS clock / countdown timer with validated load and a
// multiplexed common-anode 7-segment display (4 or 6 digits).
module rtc_display_core #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 4
) (
    input logic         clk,
    input logic         rst,
    rtc_display_if.slave bus
);

    localparam int P  = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(P);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [PW-1:0] P_LAST = PW'(P - 1);
    localparam logic [PW-1:0] P_HALF = PW'(P / 2);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     pre_q, pre_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d;
    logic [5:0]        sec_q, sec_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic       ld_ok;
    logic       step;
    logic [4:0] h_show;
    logic [7:0] h_bcd, m_bcd, s_bcd;
    logic [2:0] pos;
    logic [3:0] digit;
    logic       colon;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int k = 0; k < 6; k++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Time base, load handling and the up/down time counter
    always_comb begin
        ld_ok = (bus.ld_hour <= 5'd23) && (bus.ld_min <= 6'd59) &&
                (bus.ld_sec <= 6'd59);
        step  = tick_q && bus.run && !bus.load;

        pre_d  = (pre_q == P_LAST) ? '0 : pre_q + 1'b1;
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        done_d = done_q;
        err_d  = bus.load && !ld_ok;

        if (bus.load) begin
            if (ld_ok) begin
                pre_d  = '0;
                hour_d = bus.ld_hour;
                min_d  = bus.ld_min;
                sec_d  = bus.ld_sec;
                done_d = 1'b0;
            end
        end else if (step) begin
            if (!bus.dir) begin
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d  = 6'd0;
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else if (hour_q == 5'd0 && min_q == 6'd0 && sec_q == 6'd0) begin
                done_d = 1'b1;
            end else begin
                if (sec_q != 6'd0) begin
                    sec_d = sec_q - 6'd1;
                end else begin
                    sec_d = 6'd59;
                    if (min_q != 6'd0) begin
                        min_d = min_q - 6'd1;
                    end else begin
                        min_d  = 6'd59;
                        hour_d = hour_q - 5'd1;
                    end
                end
                if (hour_d == 5'd0 && min_d == 6'd0 && sec_d == 6'd0) begin
                    done_d = 1'b1;
                end
            end
        end

        if (!bus.dir) begin
            done_d = 1'b0;
        end

        tick_d = (pre_d == P_LAST);
    end

    always_comb begin
        scan_d = (scan_q == S_LAST) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == S_LAST) begin
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Display path works from the current index; outputs lag it by a cycle
    always_comb begin
        h_show = hour_q;
        if (bus.h12) begin
            h_show = (hour_q >= 5'd12) ? hour_q - 5'd12 : hour_q;
            if (h_show == 5'd0) begin
                h_show = 5'd12;
            end
        end
        h_bcd = to_bcd({1'b0, h_show});
        m_bcd = to_bcd(min_q);
        s_bcd = to_bcd(sec_q);

        pos = 3'(DIGITS - 1) - 3'(idx_q);
        case (pos)
            3'd0:    digit = h_bcd[7:4];
            3'd1:    digit = h_bcd[3:0];
            3'd2:    digit = m_bcd[7:4];
            3'd3:    digit = m_bcd[3:0];
            3'd4:    digit = s_bcd[7:4];
            default: digit = s_bcd[3:0];
        endcase

        seg_d = seg_of(digit);
        if (bus.h12 && pos == 3'd0 && h_bcd[7:4] == 4'd0) begin
            seg_d = 7'h7F;
        end

        colon = (pre_q < P_HALF);
        dp_d  = 1'b1;
        if (colon && (pos == 3'd1 || (DIGITS == 6 && pos == 3'd3))) begin
            dp_d = 1'b0;
        end
        if (bus.h12 && idx_q == '0 && hour_q >= 5'd12) begin
            dp_d = 1'b0;
        end

        an_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            scan_q <= '0;
            idx_q  <= '0;
            hour_q <= 5'd0;
            min_q  <= 6'd0;
            sec_q  <= 6'd0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            an_q   <= ~DIGITS'(1);
            seg_q  <= 7'h40;
            dp_q   <= 1'b1;
        end else begin
            pre_q  <= pre_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            tick_q <= tick_d;
            done_q <= done_d;
            err_q  <= err_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bus.hour     = hour_q;
    assign bus.min      = min_q;
    assign bus.sec      = sec_q;
    assign bus.tick     = tick_q;
    assign bus.done     = done_q;
    assign bus.load_err = err_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;

endmodule

// File: tb/tb_rtc_display_core.sv
// Directed bench for rtc_display_core: 4-digit and 6-digit instances
// share one stimulus stream; expectations are hand-derived constants.
module tb_rtc_display_core;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rtc_display_if #(.DIGITS(4)) b4 ();
    rtc_display_if #(.DIGITS(6)) b6 ();

    assign b6.run     = b4.run;
    assign b6.dir     = b4.dir;
    assign b6.h12     = b4.h12;
    assign b6.load    = b4.load;
    assign b6.ld_hour = b4.ld_hour;
    assign b6.ld_min  = b4.ld_min;
    assign b6.ld_sec  = b4.ld_sec;

    rtc_display_core #(
        .CLK_HZ(10), .TICK_HZ(1), .SCAN_DIV(2), .DIGITS(4)
    ) u4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    rtc_display_core #(
        .CLK_HZ(10), .TICK_HZ(1), .SCAN_DIV(2), .DIGITS(6)
    ) u6 (
        .clk(clk), .rst(rst), .bus(b6.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ph     = 0;

    logic [6:0] e4 [4];
    logic [6:0] e6 [6];
    logic       pm;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        b4.ld_hour = 5'(h);
        b4.ld_min  = 6'(m);
        b4.ld_sec  = 6'(s);
        b4.load    = 1'b1;
        step(1);
        b4.load    = 1'b0;
    endtask

    // Call right after an accepted load: prescaler phase 0 at that sample
    task automatic scan_check(input int ncyc);
        int  i4, i6, prev;
        logic col;
        logic [3:0] m4;
        logic [5:0] m6;
        ph = 0;
        step(1);
        ph = 1;
        for (int c = 0; c < ncyc; c++) begin
            prev = (ph + 9) % 10;
            col  = (prev < 5);
            i4 = -1;
            i6 = -1;
            for (int i = 0; i < 4; i++) begin
                m4 = 4'b0001 << i;
                if (b4.an == ~m4) i4 = i;
            end
            for (int i = 0; i < 6; i++) begin
                m6 = 6'b000001 << i;
                if (b6.an == ~m6) i6 = i;
            end
            chk("an4_onehot", 32'(i4 >= 0), 32'd1);
            chk("an6_onehot", 32'(i6 >= 0), 32'd1);
            if (i4 >= 0) begin
                chk($sformatf("seg4_idx%0d", i4), 32'(b4.seg), 32'(e4[i4]));
                chk($sformatf("dp4_idx%0d", i4), 32'(b4.dp),
                    32'(!((i4 == 0 && pm) || (i4 == 2 && col))));
            end
            if (i6 >= 0) begin
                chk($sformatf("seg6_idx%0d", i6), 32'(b6.seg), 32'(e6[i6]));
                chk($sformatf("dp6_idx%0d", i6), 32'(b6.dp),
                    32'(!((i6 == 0 && pm) || ((i6 == 4 || i6 == 2) && col))));
            end
            step(1);
            ph = (ph + 1) % 10;
        end
    endtask

    initial begin
        logic found;
        b4.run     = 1'b1;
        b4.dir     = 1'b0;
        b4.h12     = 1'b0;
        b4.load    = 1'b0;
        b4.ld_hour = 5'd0;
        b4.ld_min  = 6'd0;
        b4.ld_sec  = 6'd0;
        pm         = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_sec", 32'(b4.sec), 32'd0);
        chk("rst_tick", 32'(b4.tick), 32'd0);
        chk("rst_an4", 32'(b4.an), 32'hE);
        chk("rst_an6", 32'(b6.an), 32'h3E);
        chk("rst_seg", 32'(b4.seg), 32'h40);
        chk("rst_dp", 32'(b4.dp), 32'd1);
        #1 rst = 1'b0;

        // Count up from reset through one full minute
        step(9);
        chk("first_tick", 32'(b4.tick), 32'd1);
        chk("first_tick_sec", 32'(b4.sec), 32'd0);
        step(1);
        chk("sec1", 32'(b4.sec), 32'd1);
        chk("tick_low", 32'(b4.tick), 32'd0);
        for (int k = 2; k < 60; k++) begin
            step(10);
            chk($sformatf("sec%0d", k), 32'(b4.sec), 32'(k));
        end
        step(10);
        chk("min_carry", 32'(b4.min), 32'd1);
        chk("sec_wrap", 32'(b4.sec), 32'd0);

        // Midnight wrap
        do_load(23, 59, 58);
        chk("ld_hour", 32'(b4.hour), 32'd23);
        chk("ld_sec", 32'(b4.sec), 32'd58);
        step(10);
        chk("pre_wrap_sec", 32'(b4.sec), 32'd59);
        step(10);
        chk("wrap_time", {b4.hour, b4.min, b4.sec}, 32'd0);
        chk("wrap_done", 32'(b4.done), 32'd0);

        // Countdown to zero
        b4.dir = 1'b1;
        do_load(0, 0, 2);
        chk("cd_load", 32'(b4.sec), 32'd2);
        step(10);
        chk("cd_sec1", 32'(b4.sec), 32'd1);
        chk("cd_done0", 32'(b4.done), 32'd0);
        step(10);
        chk("cd_sec0", 32'(b4.sec), 32'd0);
        chk("cd_done1", 32'(b4.done), 32'd1);
        step(10);
        chk("cd_hold", {b4.hour, b4.min, b4.sec}, 32'd0);
        chk("cd_sticky", 32'(b4.done), 32'd1);
        b4.dir = 1'b0;
        step(1);
        chk("cd_dir_clr", 32'(b4.done), 32'd0);

        // Rejected loads
        do_load(24, 0, 0);
        chk("rej_hour_err", 32'(b4.load_err), 32'd1);
        chk("rej_hour_time", {b4.hour, b4.min, b4.sec}, 32'd0);
        step(1);
        chk("rej_err_pulse", 32'(b4.load_err), 32'd0);
        do_load(0, 0, 60);
        chk("rej_sec_err", 32'(b4.load_err), 32'd1);

        // Load coincident with a tick
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(1);
            if (b4.tick) found = 1'b1;
        end
        chk("tick_seen", 32'(found), 32'd1);
        do_load(12, 34, 56);
        chk("coinc_time", {b4.hour, b4.min, b4.sec}, {5'd12, 6'd34, 6'd56});
        step(9);
        chk("coinc_tick", 32'(b4.tick), 32'd1);
        chk("coinc_sec_hold", 32'(b4.sec), 32'd56);
        step(1);
        chk("coinc_sec", 32'(b4.sec), 32'd57);

        // 24-hour display at 13:05:09
        b4.run = 1'b0;
        pm = 1'b0;
        e4 = '{7'h12, 7'h40, 7'h30, 7'h79};
        e6 = '{7'h10, 7'h40, 7'h12, 7'h40, 7'h30, 7'h79};
        do_load(13, 5, 9);
        scan_check(24);

        // 12-hour display, PM
        b4.h12 = 1'b1;
        pm = 1'b1;
        e4 = '{7'h12, 7'h40, 7'h79, 7'h7F};
        e6 = '{7'h10, 7'h40, 7'h12, 7'h40, 7'h79, 7'h7F};
        do_load(13, 5, 9);
        scan_check(60);

        // 12-hour display, midnight shows 12
        pm = 1'b0;
        e4 = '{7'h40, 7'h40, 7'h24, 7'h79};
        e6 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h79};
        do_load(0, 0, 0);
        scan_check(24);

        // Async reset in the middle of a countdown
        b4.h12 = 1'b0;
        b4.run = 1'b1;
        b4.dir = 1'b1;
        do_load(0, 0, 5);
        step(15);
        chk("pre_rst_sec", 32'(b4.sec), 32'd4);
        #3 rst = 1'b1;
        b4.dir = 1'b0;
        #1;
        chk("arst_sec", 32'(b4.sec), 32'd0);
        chk("arst_done", 32'(b4.done), 32'd0);
        chk("arst_an4", 32'(b4.an), 32'hE);
        chk("arst_an6", 32'(b6.an), 32'h3E);
        chk("arst_seg", 32'(b6.seg), 32'h40);
        chk("arst_dp", 32'(b6.dp), 32'd1);
        #1 rst = 1'b0;
        step(9);
        chk("post_rst_tick", 32'(b4.tick), 32'd1);
        step(1);
        chk("post_rst_sec", 32'(b4.sec), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
